// File: rtl/tank_address_encoder_if.sv
// Tank-select bus between a store-access requester (master) and the
// tank address encoder (slave).
interface tank_address_encoder_if #(
  parameter int unsigned WORD_W  = 5,
  parameter int unsigned DIGIT_W = 5
);
  logic               rack_loc_req_valid;
  logic               rack_loc_req_write;
  logic [1:0]         rack_loc_req_tank;
  logic [WORD_W-1:0]  rack_loc_req_word;
  logic               rack_loc_req_ready;
  logic               rack_loc_f7_pos;
  logic               rack_loc_f7_neg;
  logic               rack_loc_f8_pos;
  logic               rack_loc_f8_neg;
  logic               rack_loc_t_in;
  logic               rack_loc_t_out;
  logic [DIGIT_W-1:0] rack_loc_digit;
  logic [WORD_W-1:0]  rack_loc_word;
  logic               rack_loc_done;

  modport master (
    output rack_loc_req_valid, rack_loc_req_write, rack_loc_req_tank, rack_loc_req_word,
    input  rack_loc_req_ready, rack_loc_f7_pos, rack_loc_f7_neg, rack_loc_f8_pos,
           rack_loc_f8_neg, rack_loc_t_in, rack_loc_t_out, rack_loc_digit,
           rack_loc_word, rack_loc_done
  );

  modport slave (
    input  rack_loc_req_valid, rack_loc_req_write, rack_loc_req_tank, rack_loc_req_word,
    output rack_loc_req_ready, rack_loc_f7_pos, rack_loc_f7_neg, rack_loc_f8_pos,
           rack_loc_f8_neg, rack_loc_t_in, rack_loc_t_out, rack_loc_digit,
           rack_loc_word, rack_loc_done
  );
endinterface

// File: rtl/tank_address_encoder.sv
// Tank address encoder: drives the F7/F8 tank-order lines and times a single
// in/out strobe to the addressed word's slot in the recirculating delay line.
module tank_address_encoder #(
  parameter int unsigned DIGITS_PER_WORD = 18,
  parameter int unsigned WORDS_PER_TANK  = 32,
  parameter int unsigned WORD_W          = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  tank_address_encoder_if.slave bus
);
  localparam int unsigned        DIGIT_W    = $clog2(DIGITS_PER_WORD);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGITS_PER_WORD - 1);
  localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(WORDS_PER_TANK - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAIT,
    ST_XFER,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [1:0]          tank_q, tank_d;
  logic [WORD_W-1:0]   tgt_q, tgt_d;
  logic                write_q, write_d;
  logic                digit_wrap;
  logic                slot_hit;
  logic                busy_d;

  logic                ready_q;
  logic                f7_pos_q, f7_neg_q, f8_pos_q, f8_neg_q;
  logic                t_in_q, t_out_q;
  logic                done_q;

  // Free-running recirculation position, independent of the transfer FSM.
  always_comb begin
    digit_wrap = (digit_q == DIGIT_LAST);
    digit_d    = digit_wrap ? '0 : digit_q + DIGIT_W'(1);
    word_d     = word_q;
    if (digit_wrap) begin
      word_d = (word_q == WORD_LAST) ? '0 : word_q + WORD_W'(1);
    end
  end

  // Outputs are registered from next-state values, so the slot test looks at
  // the counters of the coming cycle to align the first strobe with digit 0.
  assign slot_hit = (digit_d == '0) && (word_d == tgt_q);

  always_comb begin
    state_d = state_q;
    tank_d  = tank_q;
    tgt_d   = tgt_q;
    write_d = write_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.rack_loc_req_valid && ready_q) begin
          state_d = ST_SELECT;
          tank_d  = bus.rack_loc_req_tank;
          tgt_d   = bus.rack_loc_req_word;
          write_d = bus.rack_loc_req_write;
        end
      end
      ST_SELECT, ST_WAIT: begin
        state_d = slot_hit ? ST_XFER : ST_WAIT;
      end
      ST_XFER: begin
        if (digit_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      digit_q  <= '0;
      word_q   <= '0;
      tank_q   <= '0;
      tgt_q    <= '0;
      write_q  <= 1'b0;
      ready_q  <= 1'b0;
      f7_pos_q <= 1'b0;
      f7_neg_q <= 1'b0;
      f8_pos_q <= 1'b0;
      f8_neg_q <= 1'b0;
      t_in_q   <= 1'b0;
      t_out_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      word_q   <= word_d;
      tank_q   <= tank_d;
      tgt_q    <= tgt_d;
      write_q  <= write_d;
      ready_q  <= (state_d == ST_IDLE);
      f7_pos_q <= busy_d &  tank_d[0];
      f7_neg_q <= busy_d & ~tank_d[0];
      f8_pos_q <= busy_d &  tank_d[1];
      f8_neg_q <= busy_d & ~tank_d[1];
      t_in_q   <= (state_d == ST_XFER) &  write_d;
      t_out_q  <= (state_d == ST_XFER) & ~write_d;
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign bus.rack_loc_req_ready = ready_q;
  assign bus.rack_loc_f7_pos    = f7_pos_q;
  assign bus.rack_loc_f7_neg    = f7_neg_q;
  assign bus.rack_loc_f8_pos    = f8_pos_q;
  assign bus.rack_loc_f8_neg    = f8_neg_q;
  assign bus.rack_loc_t_in      = t_in_q;
  assign bus.rack_loc_t_out     = t_out_q;
  assign bus.rack_loc_digit     = digit_q;
  assign bus.rack_loc_word      = word_q;
  assign bus.rack_loc_done      = done_q;
endmodule

// File: tb/tb_tank_address_encoder.sv
// Scoreboard bench for tank_address_encoder: directed requests push expected
// transfers; a monitor collects each transfer and checks it on the done pulse.
module tb_tank_address_encoder;
  localparam int unsigned DPW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tank_address_encoder_if #(.WORD_W(5), .DIGIT_W(5)) bus ();

  tank_address_encoder #(
    .DIGITS_PER_WORD(18),
    .WORDS_PER_TANK (32),
    .WORD_W         (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  f;      // {f7_pos, f7_neg, f8_pos, f8_neg}
    int unsigned tin;
    int unsigned tout;
    int unsigned lat;    // accept cycle -> first strobe cycle
    logic [4:0]  word;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   quiet = 1'b0;

  // ---------------- monitor ----------------
  int unsigned md = 0, mw = 0;
  bit          active = 1'b0, chk_after = 1'b0;
  int unsigned rel, start_rel, tin_cnt, tout_cnt, both_cnt;
  bit          seen, f_var, word_var, ready_hi;
  logic [3:0]  f_obs, f_now;
  logic [4:0]  s_word;
  exp_t        e;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      f_now = {bus.rack_loc_f7_pos, bus.rack_loc_f7_neg, bus.rack_loc_f8_pos, bus.rack_loc_f8_neg};
      if (rst) begin
        total++;
        if ({bus.rack_loc_req_ready, f_now, bus.rack_loc_t_in, bus.rack_loc_t_out,
             bus.rack_loc_done, bus.rack_loc_digit, bus.rack_loc_word} !== '0) begin
          bad++;
          $display("FAIL reset_outputs t=%0t ready=%b f=%b tin=%b tout=%b done=%b digit=%0d word=%0d required all 0",
                   $time, bus.rack_loc_req_ready, f_now, bus.rack_loc_t_in, bus.rack_loc_t_out,
                   bus.rack_loc_done, bus.rack_loc_digit, bus.rack_loc_word);
        end
        md = 0; mw = 0; active = 1'b0; chk_after = 1'b0;
      end else begin
        total++;
        if (bus.rack_loc_digit !== 5'(md) || bus.rack_loc_word !== 5'(mw)) begin
          bad++;
          $display("FAIL counters t=%0t got word/digit=%0d/%0d required %0d/%0d",
                   $time, bus.rack_loc_word, bus.rack_loc_digit, mw, md);
        end
        if (md == DPW - 1) begin
          md = 0;
          mw = (mw + 1) % 32;
        end else begin
          md++;
        end

        if (quiet) begin
          total++;
          if (bus.rack_loc_req_ready !== 1'b1 || f_now !== 4'b0 || bus.rack_loc_t_in !== 1'b0 ||
              bus.rack_loc_t_out !== 1'b0 || bus.rack_loc_done !== 1'b0) begin
            bad++;
            $display("FAIL free_run_idle t=%0t ready=%b f=%b tin=%b tout=%b done=%b required ready=1 rest 0",
                     $time, bus.rack_loc_req_ready, f_now, bus.rack_loc_t_in, bus.rack_loc_t_out, bus.rack_loc_done);
          end
        end

        if (chk_after) begin
          chk_after = 1'b0;
          total++;
          if (bus.rack_loc_req_ready !== 1'b1 || bus.rack_loc_done !== 1'b0) begin
            bad++;
            $display("FAIL after_done t=%0t ready=%b done=%b required ready=1 done=0",
                     $time, bus.rack_loc_req_ready, bus.rack_loc_done);
          end
        end

        if (active) begin
          rel++;
          if (rel == 1) f_obs = f_now;
          else if (f_now !== f_obs) f_var = 1'b1;
          if (bus.rack_loc_req_ready) ready_hi = 1'b1;
          if (bus.rack_loc_t_in || bus.rack_loc_t_out) begin
            if (!seen) begin
              seen = 1'b1; start_rel = rel; s_word = bus.rack_loc_word;
            end else if (bus.rack_loc_word !== s_word) begin
              word_var = 1'b1;
            end
            if (bus.rack_loc_t_in)  tin_cnt++;
            if (bus.rack_loc_t_out) tout_cnt++;
            if (bus.rack_loc_t_in && bus.rack_loc_t_out) both_cnt++;
          end
          if (bus.rack_loc_done) begin
            active = 1'b0;
            chk_after = 1'b1;
            total++;
            if (sb.size() == 0) begin
              bad++;
              $display("FAIL done_unexpected t=%0t got done with empty scoreboard required no done", $time);
            end else begin
              e = sb.pop_front();
              total++;
              if (f_obs !== e.f || f_var) begin
                bad++;
                $display("FAIL f_lines got %b (changed=%0b) required %b steady", f_obs, f_var, e.f);
              end
              total++;
              if (tin_cnt != e.tin || tout_cnt != e.tout || both_cnt != 0) begin
                bad++;
                $display("FAIL strobe_count got tin=%0d tout=%0d both=%0d required tin=%0d tout=%0d both=0",
                         tin_cnt, tout_cnt, both_cnt, e.tin, e.tout);
              end
              total++;
              if (!seen || start_rel != e.lat) begin
                bad++;
                $display("FAIL latency got %0d (strobe seen=%0b) required %0d", start_rel, seen, e.lat);
              end
              total++;
              if (s_word !== e.word || word_var) begin
                bad++;
                $display("FAIL strobe_word got %0d (varied=%0b) required %0d", s_word, word_var, e.word);
              end
              total++;
              if (rel - start_rel != DPW || ready_hi) begin
                bad++;
                $display("FAIL done_timing got done %0d cycles after first strobe ready_seen=%0b required %0d and 0",
                         rel - start_rel, ready_hi, DPW);
              end
            end
          end
        end else begin
          total++;
          if (bus.rack_loc_t_in || bus.rack_loc_t_out || bus.rack_loc_done || f_now != 4'b0) begin
            bad++;
            $display("FAIL idle_outputs t=%0t tin=%b tout=%b done=%b f=%b required all 0",
                     $time, bus.rack_loc_t_in, bus.rack_loc_t_out, bus.rack_loc_done, f_now);
          end
          if (bus.rack_loc_req_valid && bus.rack_loc_req_ready) begin
            active = 1'b1; rel = 0; seen = 1'b0; f_var = 1'b0; word_var = 1'b0; ready_hi = 1'b0;
            tin_cnt = 0; tout_cnt = 0; both_cnt = 0; start_rel = 0; f_obs = '0; s_word = '0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic wr, input logic [1:0] tk, input logic [4:0] wd,
                       input int unsigned at_word, input int unsigned at_digit,
                       input logic [3:0] f, input int unsigned lat, input bit push);
    int unsigned n = 0;
    exp_t x;
    @(negedge clk);
    while (!(bus.rack_loc_req_ready === 1'b1 && bus.rack_loc_digit == 5'(at_digit) &&
             bus.rack_loc_word == 5'(at_word)) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1500) begin
      total++; bad++;
      $display("FAIL issue_wait got no ready slot at word/digit %0d/%0d within 1500 cycles", at_word, at_digit);
    end else begin
      if (push) begin
        x.f = f; x.tin = wr ? DPW : 0; x.tout = wr ? 0 : DPW; x.lat = lat; x.word = wd;
        sb.push_back(x);
      end
      bus.rack_loc_req_write = wr;
      bus.rack_loc_req_tank  = tk;
      bus.rack_loc_req_word  = wd;
      bus.rack_loc_req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.rack_loc_req_valid = 1'b0;
      bus.rack_loc_req_write = ~wr;
      bus.rack_loc_req_tank  = ~tk;
      bus.rack_loc_req_word  = ~wd;
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((sb.size() != 0 || bus.rack_loc_req_ready !== 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL drain_timeout got %0d pending transfers required 0", sb.size());
    end
  endtask

  initial begin
    int unsigned n, k;
    exp_t x;
    bus.rack_loc_req_valid = 1'b0;
    bus.rack_loc_req_write = 1'b0;
    bus.rack_loc_req_tank  = '0;
    bus.rack_loc_req_word  = '0;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 quiet = 1'b1;
    repeat (600) @(posedge clk);
    #1 quiet = 1'b0;

    // read tank 2 word 5 at 0/3: slot at 90, accept at 3
    issue(1'b0, 2'd2, 5'd5, 0, 3, 4'b0110, 87, 1'b1);
    drain();
    // write tank 3 word 7 at 7/4: current slot skipped, next one 576 later
    issue(1'b1, 2'd3, 5'd7, 7, 4, 4'b1010, 572, 1'b1);
    drain();
    // write tank 0 word 0 at 31/16: minimum latency
    issue(1'b1, 2'd0, 5'd0, 31, 16, 4'b0101, 2, 1'b1);
    drain();
    // read tank 1 word 9 at 8/17: slot starts at A+1, maximum latency
    issue(1'b0, 2'd1, 5'd9, 8, 17, 4'b1001, 577, 1'b1);
    drain();

    // busy: second request held valid during first transfer
    issue(1'b0, 2'd1, 5'd10, 2, 0, 4'b1001, 144, 1'b1);
    x.f = 4'b0110; x.tin = DPW; x.tout = 0; x.lat = 431; x.word = 5'd3;
    sb.push_back(x);
    bus.rack_loc_req_write = 1'b1;
    bus.rack_loc_req_tank  = 2'd2;
    bus.rack_loc_req_word  = 5'd3;
    bus.rack_loc_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.rack_loc_req_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL busy_ready got ready=0 for 400 cycles required ready=1");
    end
    @(posedge clk);
    #1 bus.rack_loc_req_valid = 1'b0;
    drain();

    // reset in the middle of a tank-1 read window
    issue(1'b0, 2'd1, 5'd4, 3, 0, 4'b1001, 18, 1'b0);
    n = 0; k = 0;
    while (k < 5 && n < 400) begin
      @(negedge clk);
      if (bus.rack_loc_t_out === 1'b1) k++;
      n++;
    end
    total++;
    if (k < 5) begin
      bad++;
      $display("FAIL midreset_strobe got %0d t_out cycles required 5", k);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if ({bus.rack_loc_req_ready, bus.rack_loc_f7_pos, bus.rack_loc_f7_neg, bus.rack_loc_f8_pos,
         bus.rack_loc_f8_neg, bus.rack_loc_t_in, bus.rack_loc_t_out, bus.rack_loc_done,
         bus.rack_loc_digit, bus.rack_loc_word} !== '0) begin
      bad++;
      $display("FAIL async_reset got t_out=%b f7p=%b digit=%0d word=%0d required all 0",
               bus.rack_loc_t_out, bus.rack_loc_f7_pos, bus.rack_loc_digit, bus.rack_loc_word);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (40) @(posedge clk);
    // a normal transfer after the abandoned one
    issue(1'b1, 2'd1, 5'd2, 1, 0, 4'b1001, 18, 1'b1);
    drain();
    repeat (5) @(posedge clk);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got %0d entries required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
